// File: rtl/arcade_input_pkg.sv
// Scan codes, control bit positions and shared types for the arcade input front end.
// Declarations plus the orientation remap helper; no state.
package arcade_input_pkg;

  localparam logic [7:0] SC_UP        = 8'h75;
  localparam logic [7:0] SC_DOWN      = 8'h72;
  localparam logic [7:0] SC_LEFT      = 8'h6B;
  localparam logic [7:0] SC_RIGHT     = 8'h74;
  localparam logic [7:0] SC_FIRE_A    = 8'h29;
  localparam logic [7:0] SC_FIRE_B    = 8'h14;
  localparam logic [7:0] SC_START1_A  = 8'h05;
  localparam logic [7:0] SC_START1_B  = 8'h16;
  localparam logic [7:0] SC_START2_A  = 8'h06;
  localparam logic [7:0] SC_START2_B  = 8'h1E;
  localparam logic [7:0] SC_COIN_A    = 8'h2E;
  localparam logic [7:0] SC_COIN_B    = 8'h36;
  localparam logic [7:0] SC_P2_UP     = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN   = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT   = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT  = 8'h34;
  localparam logic [7:0] SC_P2_FIRE   = 8'h1C;
  localparam logic [7:0] SC_TEST      = 8'h2C;

  localparam int CTL_RIGHT  = 0;
  localparam int CTL_LEFT   = 1;
  localparam int CTL_DOWN   = 2;
  localparam int CTL_UP     = 3;
  localparam int CTL_FIRE   = 4;

  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  typedef logic [4:0] ctrl_t;

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_REL} coin_state_t;

  // One held bit per scan code; aliases for the same function are ORed later.
  typedef struct packed {
    logic up, down, left, right, fire_a, fire_b;
    logic start1_a, start1_b, start2_a, start2_b;
    logic coin_a, coin_b;
    logic p2_up, p2_down, p2_left, p2_right, p2_fire;
    logic test;
  } key_reg_t;

  function automatic ctrl_t rotate_ctrl(input ctrl_t raw, input logic rot);
    ctrl_t r;
    r = raw;
    if (rot) begin
      r[CTL_UP]    = raw[CTL_LEFT];
      r[CTL_DOWN]  = raw[CTL_RIGHT];
      r[CTL_LEFT]  = raw[CTL_DOWN];
      r[CTL_RIGHT] = raw[CTL_UP];
    end
    return r;
  endfunction

endpackage

// File: rtl/arcade_input_decoder_if.sv
// Input/output bundle between the HPS key/joystick sources and the arcade input decoder.
// Plain wires; no handshake, every field is sampled or driven every cycle.
interface arcade_input_decoder_if;
  import arcade_input_pkg::*;

  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  ctrl_t       p1_ctrl;
  ctrl_t       p2_ctrl;
  logic        start1;
  logic        start2;
  logic        coin1;
  logic        test;

  modport master (
    output ps2_key, joystick_0, joystick_1, rotate,
    input  p1_ctrl, p2_ctrl, start1, start2, coin1, test
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, rotate,
    output p1_ctrl, p2_ctrl, start1, start2, coin1, test
  );

endinterface

// File: rtl/coin_pulse_gen.sv
// Stretches a coin request into a COIN_CYCLES-long pulse that fires once per press.
// Latency: coin rises the cycle after req is seen in IDLE; no backpressure, extra presses are absorbed.
module coin_pulse_gen
  import arcade_input_pkg::*;
#(
  parameter int COIN_CYCLES = 1200000,
  parameter int CNT_W       = 21
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req,
  output logic coin
);

  coin_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      coin    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coin    <= (state_d == PULSE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(COIN_CYCLES - 1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) state_d = WAIT_REL;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      // A request still held after the pulse must be released before re-arming.
      WAIT_REL: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/arcade_input_decoder.sv
// Decodes the PS/2 key stream into held keys, merges joysticks, applies rotation and stretches coin.
// Latency: key toggle to outputs 2 cycles, joystick to outputs 1 cycle; no backpressure.
module arcade_input_decoder
  import arcade_input_pkg::*;
#(
  parameter int COIN_CYCLES   = 1200000,
  parameter int CNT_W         = 21,
  parameter bit COIN_ON_START = 1'b1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  arcade_input_decoder_if.slave bus
);

  logic     primed_q, old_toggle_q;
  logic     key_evt, key_pressed;
  key_reg_t keys_q, keys_d;
  ctrl_t    kb_p1, kb_p2, p1_raw, p2_raw;
  logic     start1_raw, start2_raw, coin_req;
  logic     unused_bits;

  assign unused_bits = &{1'b0, bus.ps2_key[8], bus.joystick_0[15:8], bus.joystick_1[15:8]};

  // The first cycle out of reset only captures the toggle level so a stale strobe is not decoded.
  assign key_evt     = primed_q && (bus.ps2_key[10] != old_toggle_q);
  assign key_pressed = bus.ps2_key[9];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      primed_q     <= 1'b0;
      old_toggle_q <= 1'b0;
      keys_q       <= '0;
    end else begin
      primed_q     <= 1'b1;
      old_toggle_q <= bus.ps2_key[10];
      keys_q       <= keys_d;
    end
  end

  always_comb begin
    keys_d = keys_q;
    if (key_evt) begin
      case (bus.ps2_key[7:0])
        SC_UP:       keys_d.up       = key_pressed;
        SC_DOWN:     keys_d.down     = key_pressed;
        SC_LEFT:     keys_d.left     = key_pressed;
        SC_RIGHT:    keys_d.right    = key_pressed;
        SC_FIRE_A:   keys_d.fire_a   = key_pressed;
        SC_FIRE_B:   keys_d.fire_b   = key_pressed;
        SC_START1_A: keys_d.start1_a = key_pressed;
        SC_START1_B: keys_d.start1_b = key_pressed;
        SC_START2_A: keys_d.start2_a = key_pressed;
        SC_START2_B: keys_d.start2_b = key_pressed;
        SC_COIN_A:   keys_d.coin_a   = key_pressed;
        SC_COIN_B:   keys_d.coin_b   = key_pressed;
        SC_P2_UP:    keys_d.p2_up    = key_pressed;
        SC_P2_DOWN:  keys_d.p2_down  = key_pressed;
        SC_P2_LEFT:  keys_d.p2_left  = key_pressed;
        SC_P2_RIGHT: keys_d.p2_right = key_pressed;
        SC_P2_FIRE:  keys_d.p2_fire  = key_pressed;
        SC_TEST:     keys_d.test     = key_pressed;
        default: ;
      endcase
    end
  end

  always_comb begin
    kb_p1 = '0;
    kb_p1[CTL_RIGHT] = keys_q.right;
    kb_p1[CTL_LEFT]  = keys_q.left;
    kb_p1[CTL_DOWN]  = keys_q.down;
    kb_p1[CTL_UP]    = keys_q.up;
    kb_p1[CTL_FIRE]  = keys_q.fire_a | keys_q.fire_b;
    kb_p2 = '0;
    kb_p2[CTL_RIGHT] = keys_q.p2_right;
    kb_p2[CTL_LEFT]  = keys_q.p2_left;
    kb_p2[CTL_DOWN]  = keys_q.p2_down;
    kb_p2[CTL_UP]    = keys_q.p2_up;
    kb_p2[CTL_FIRE]  = keys_q.p2_fire;
  end

  assign p1_raw     = kb_p1 | bus.joystick_0[4:0];
  assign p2_raw     = kb_p2 | bus.joystick_1[4:0];
  assign start1_raw = keys_q.start1_a | keys_q.start1_b
                    | bus.joystick_0[JOY_START1] | bus.joystick_1[JOY_START1];
  assign start2_raw = keys_q.start2_a | keys_q.start2_b
                    | bus.joystick_0[JOY_START2] | bus.joystick_1[JOY_START2];
  assign coin_req   = keys_q.coin_a | keys_q.coin_b
                    | bus.joystick_0[JOY_COIN] | bus.joystick_1[JOY_COIN]
                    | (COIN_ON_START && (start1_raw || start2_raw));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bus.p1_ctrl <= '0;
      bus.p2_ctrl <= '0;
      bus.start1  <= 1'b0;
      bus.start2  <= 1'b0;
      bus.test    <= 1'b0;
    end else begin
      bus.p1_ctrl <= rotate_ctrl(p1_raw, bus.rotate);
      bus.p2_ctrl <= rotate_ctrl(p2_raw, bus.rotate);
      bus.start1  <= start1_raw;
      bus.start2  <= start2_raw;
      bus.test    <= keys_q.test;
    end
  end

  coin_pulse_gen #(
    .COIN_CYCLES (COIN_CYCLES),
    .CNT_W       (CNT_W)
  ) u_coin (
    .clk_sys (clk_sys),
    .reset   (reset),
    .req     (coin_req),
    .coin    (bus.coin1)
  );

endmodule

// File: tb/tb_arcade_input_decoder.sv
// Scoreboard bench: two decoders (coin-on-start on and off) share one stimulus stream.
// Expected outputs are queued when stimulus is driven and popped one per cycle.
module tb_arcade_input_decoder;

  logic        clk_sys;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] j0, j1;
  logic        rotate;
  logic        tgl;

  int vectors;
  int miscompares;

  logic [12:0] ctrl_q[$];
  logic [1:0]  coin_q[$];

  arcade_input_decoder_if bus_a();
  arcade_input_decoder_if bus_b();

  assign bus_a.ps2_key    = ps2_key;
  assign bus_a.joystick_0 = j0;
  assign bus_a.joystick_1 = j1;
  assign bus_a.rotate     = rotate;
  assign bus_b.ps2_key    = ps2_key;
  assign bus_b.joystick_0 = j0;
  assign bus_b.joystick_1 = j1;
  assign bus_b.rotate     = rotate;

  arcade_input_decoder #(.COIN_CYCLES(8), .CNT_W(4), .COIN_ON_START(1'b1)) dut_a (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus_a)
  );

  arcade_input_decoder #(.COIN_CYCLES(8), .CNT_W(4), .COIN_ON_START(1'b0)) dut_b (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus_b)
  );

  wire [12:0] obs_ctrl = {bus_a.p1_ctrl, bus_a.p2_ctrl, bus_a.start1, bus_a.start2, bus_a.test};
  wire [1:0]  obs_coin = {bus_a.coin1, bus_b.coin1};

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // {pressed, extended, code, p1, p2, {start1,start2,test}} after each key event
  localparam logic [22:0] KEY_TAB [0:35] = '{
    {1'b0,1'b0,8'h75,5'b00000,5'b00000,3'b000},
    {1'b1,1'b0,8'h75,5'b01000,5'b00000,3'b000},
    {1'b0,1'b0,8'h75,5'b00000,5'b00000,3'b000},
    {1'b1,1'b1,8'h6B,5'b00010,5'b00000,3'b000},
    {1'b1,1'b0,8'h29,5'b10010,5'b00000,3'b000},
    {1'b1,1'b0,8'h14,5'b10010,5'b00000,3'b000},
    {1'b0,1'b0,8'h29,5'b10010,5'b00000,3'b000},
    {1'b0,1'b0,8'h14,5'b00010,5'b00000,3'b000},
    {1'b0,1'b0,8'h6B,5'b00000,5'b00000,3'b000},
    {1'b1,1'b0,8'h72,5'b00100,5'b00000,3'b000},
    {1'b1,1'b1,8'h74,5'b00101,5'b00000,3'b000},
    {1'b0,1'b0,8'h72,5'b00001,5'b00000,3'b000},
    {1'b0,1'b0,8'h74,5'b00000,5'b00000,3'b000},
    {1'b1,1'b0,8'h99,5'b00000,5'b00000,3'b000},
    {1'b1,1'b0,8'h2D,5'b00000,5'b01000,3'b000},
    {1'b1,1'b0,8'h1C,5'b00000,5'b11000,3'b000},
    {1'b1,1'b1,8'h2B,5'b00000,5'b11100,3'b000},
    {1'b1,1'b0,8'h23,5'b00000,5'b11110,3'b000},
    {1'b1,1'b0,8'h34,5'b00000,5'b11111,3'b000},
    {1'b0,1'b0,8'h2D,5'b00000,5'b10111,3'b000},
    {1'b0,1'b0,8'h1C,5'b00000,5'b00111,3'b000},
    {1'b0,1'b0,8'h2B,5'b00000,5'b00011,3'b000},
    {1'b0,1'b0,8'h23,5'b00000,5'b00001,3'b000},
    {1'b0,1'b0,8'h34,5'b00000,5'b00000,3'b000},
    {1'b1,1'b0,8'h05,5'b00000,5'b00000,3'b100},
    {1'b1,1'b0,8'h16,5'b00000,5'b00000,3'b100},
    {1'b0,1'b0,8'h05,5'b00000,5'b00000,3'b100},
    {1'b0,1'b0,8'h16,5'b00000,5'b00000,3'b000},
    {1'b1,1'b0,8'h06,5'b00000,5'b00000,3'b010},
    {1'b1,1'b0,8'h1E,5'b00000,5'b00000,3'b010},
    {1'b0,1'b0,8'h06,5'b00000,5'b00000,3'b010},
    {1'b0,1'b0,8'h1E,5'b00000,5'b00000,3'b000},
    {1'b1,1'b0,8'h2C,5'b00000,5'b00000,3'b001},
    {1'b0,1'b1,8'h2C,5'b00000,5'b00000,3'b000},
    {1'b1,1'b0,8'h2E,5'b00000,5'b00000,3'b000},
    {1'b0,1'b0,8'h2E,5'b00000,5'b00000,3'b000}
  };

  localparam logic [8:0] B2B_TAB [0:5] = '{
    {1'b1,8'h16}, {1'b1,8'h1E}, {1'b1,8'h2C}, {1'b0,8'h16}, {1'b0,8'h1E}, {1'b0,8'h2C}
  };
  localparam logic [2:0] B2B_EXP [1:8] = '{
    3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000, 3'b000
  };

  function automatic logic [4:0] rot_model(input logic [4:0] r, input logic en);
    return en ? {r[4], r[1], r[0], r[2], r[3]} : r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    tgl     = ~tgl;
    ps2_key = {tgl, pressed, ext, code};
  endtask

  task automatic do_reset();
    j0 = '0; j1 = '0; rotate = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    logic [12:0] e;
    logic [1:0]  ec;
    reset = 1'b1; tgl = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    tick(3);
    vectors++;
    if ({obs_ctrl, obs_coin} !== 15'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected %b", {obs_ctrl, obs_coin}, 15'b0);
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin ctrl_q.push_back('0); coin_q.push_back(2'b00); end
    while (ctrl_q.size() != 0) begin
      tick(1);
      e = ctrl_q.pop_front(); ec = coin_q.pop_front();
      vectors++;
      if ({obs_ctrl, obs_coin} !== {e, ec}) begin
        miscompares++;
        $display("FAIL reset_prime: got %b expected %b", {obs_ctrl, obs_coin}, {e, ec});
      end
    end
  endtask

  task automatic test_key_decode();
    logic [22:0] row;
    logic [12:0] prev, e;
    do_reset();
    prev = '0;
    for (int i = 0; i < 36; i++) begin
      row = KEY_TAB[i];
      send_key(row[22], row[21], row[20:13]);
      ctrl_q.push_back(prev);
      ctrl_q.push_back(row[12:0]);
      prev = row[12:0];
      while (ctrl_q.size() != 0) begin
        tick(1);
        e = ctrl_q.pop_front();
        vectors++;
        if (obs_ctrl !== e) begin
          miscompares++;
          $display("FAIL key_decode[%0d] code %h: got %b expected %b", i, row[20:13], obs_ctrl, e);
        end
      end
    end
  endtask

  task automatic test_rotate();
    logic [12:0] e;
    logic [15:0] a, b;
    logic        r;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if (i == 0)      begin a = 16'h0008; b = 16'h0000; r = 1'b1; end
      else if (i == 1) begin a = 16'h0000; b = 16'h0001; r = 1'b1; end
      else if (i == 2) begin a = 16'h0012; b = 16'h0004; r = 1'b1; end
      else begin a = 16'($urandom); b = 16'($urandom); r = 1'($urandom); end
      j0 = a; j1 = b; rotate = r;
      ctrl_q.push_back({rot_model(a[4:0], r), rot_model(b[4:0], r), a[5] | b[5], a[6] | b[6], 1'b0});
      tick(1);
      e = ctrl_q.pop_front();
      vectors++;
      if (obs_ctrl !== e) begin
        miscompares++;
        $display("FAIL rotate[%0d] j0=%h j1=%h rot=%b: got %b expected %b", i, a, b, r, obs_ctrl, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [12:0] e;
    do_reset();
    j0 = 16'h0001;
    send_key(1'b1, 1'b0, 8'h72);
    ctrl_q.push_back({5'b00001, 8'b0});
    ctrl_q.push_back({5'b00101, 8'b0});
    while (ctrl_q.size() != 0) begin
      tick(1);
      e = ctrl_q.pop_front();
      vectors++;
      if (obs_ctrl !== e) begin
        miscompares++;
        $display("FAIL simultaneous_press: got %b expected %b", obs_ctrl, e);
      end
    end
    j0 = 16'h0000;
    send_key(1'b0, 1'b0, 8'h72);
    ctrl_q.push_back({5'b00100, 8'b0});
    ctrl_q.push_back(13'b0);
    while (ctrl_q.size() != 0) begin
      tick(1);
      e = ctrl_q.pop_front();
      vectors++;
      if (obs_ctrl !== e) begin
        miscompares++;
        $display("FAIL simultaneous_release: got %b expected %b", obs_ctrl, e);
      end
    end
  endtask

  task automatic test_coin_hold();
    logic [1:0] ec;
    int         hold;
    logic [7:0] code;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      hold = (k == 0) ? 50 : 20;
      code = (k == 2) ? 8'h36 : 8'h2E;
      send_key(1'b1, 1'b0, code);
      for (int c = 1; c <= hold; c++) coin_q.push_back((c >= 2 && c <= 9) ? 2'b11 : 2'b00);
      send_key_release_after: begin end
      while (coin_q.size() != 0) begin
        tick(1);
        ec = coin_q.pop_front();
        vectors++;
        if (obs_coin !== ec) begin
          miscompares++;
          $display("FAIL coin_hold[%0d]: coin_a,coin_b=%b expected %b", k, obs_coin, ec);
        end
      end
      send_key(1'b0, 1'b0, code);
      for (int c = 0; c < 4; c++) coin_q.push_back(2'b00);
      while (coin_q.size() != 0) begin
        tick(1);
        ec = coin_q.pop_front();
        vectors++;
        if (obs_coin !== ec) begin
          miscompares++;
          $display("FAIL coin_release[%0d]: coin_a,coin_b=%b expected %b", k, obs_coin, ec);
        end
      end
    end
  endtask

  task automatic test_start_coin();
    logic [12:0] e;
    logic [1:0]  ec;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      if (s == 0) j0 = 16'h0020;
      else        j1 = 16'h0040;
      for (int c = 1; c <= 12; c++) begin
        ctrl_q.push_back((c == 1) ? ((s == 0) ? 13'b100 : 13'b010) : 13'b0);
        coin_q.push_back((c <= 8) ? 2'b10 : 2'b00);
      end
      for (int c = 1; c <= 12; c++) begin
        tick(1);
        e = ctrl_q.pop_front(); ec = coin_q.pop_front();
        vectors++;
        if ({obs_ctrl, obs_coin} !== {e, ec}) begin
          miscompares++;
          $display("FAIL start_coin[%0d] cycle %0d: got %b expected %b", s, c, {obs_ctrl, obs_coin}, {e, ec});
        end
        if (c == 1) begin j0 = '0; j1 = '0; end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [12:0] e;
    logic [1:0]  ec;
    do_reset();
    j0 = 16'h0089;
    for (int c = 1; c <= 14; c++) begin
      ctrl_q.push_back((c <= 3) ? {5'b01001, 8'b0} : 13'b0);
      coin_q.push_back((c <= 3) ? 2'b11 : 2'b00);
    end
    for (int c = 1; c <= 14; c++) begin
      tick(1);
      e = ctrl_q.pop_front(); ec = coin_q.pop_front();
      vectors++;
      if ({obs_ctrl, obs_coin} !== {e, ec}) begin
        miscompares++;
        $display("FAIL reset_mid_pulse cycle %0d: got %b expected %b", c, {obs_ctrl, obs_coin}, {e, ec});
      end
      if (c == 3) reset = 1'b1;
      if (c == 4) begin reset = 1'b0; j0 = '0; end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    logic [8:0]  row;
    do_reset();
    for (int c = 1; c <= 8; c++) ctrl_q.push_back({10'b0, B2B_EXP[c]});
    row = B2B_TAB[0];
    send_key(row[8], 1'b0, row[7:0]);
    for (int c = 1; c <= 8; c++) begin
      tick(1);
      e = ctrl_q.pop_front();
      vectors++;
      if (obs_ctrl !== e) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs_ctrl, e);
      end
      if (c <= 5) begin
        row = B2B_TAB[c];
        send_key(row[8], 1'b0, row[7:0]);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; ps2_key = '0; j0 = '0; j1 = '0; rotate = 1'b0; tgl = 1'b0;
    test_reset();
    test_key_decode();
    test_rotate();
    test_simultaneous();
    test_coin_hold();
    test_start_coin();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
